// File: rtl/remote_comm_pkg.sv
// remote_comm_pkg: shared types and constants for the host-side UART command
// link (remote_comm top and its remote_uart sub-module).
//   tx_state_t        command FSM states (IDLE, TX_HIGH, TX_LOW)
//   DEFAULT_BAUD_DIV  clocks per UART bit, 19200 baud at 50 MHz
//   POS_ACK           response byte meaning positive acknowledge
package remote_comm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    TX_HIGH = 2'd1,
    TX_LOW  = 2'd2
  } tx_state_t;

  localparam int         DEFAULT_BAUD_DIV = 2604;
  localparam logic [7:0] POS_ACK          = 8'hA5;

endpackage

// File: rtl/remote_uart.sv
// remote_uart: 8N1 UART transmitter and receiver pair.
// Optional receiver: compiled in only when REMOTE_COMM_RX_EN is defined;
// otherwise rx_data/rx_rdy are tied to zero.
// Ports:
//   clk, srst          clock, synchronous active-high reset
//   tx_load, tx_data   load a byte; may coincide with tx_done (no idle gap)
//   tx_busy, tx_done   frame in progress / last cycle of the stop bit
//   tx                 serial out, idles high
//   rx                 asynchronous serial in, idles high
//   rx_data, rx_rdy    last received byte / set at stop sample, cleared on start
module remote_uart
  import remote_comm_pkg::*;
#(
  parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
  input  logic       clk,
  input  logic       srst,
  input  logic       tx_load,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_rdy
);

  localparam logic [11:0] BAUD_LAST = 12'(BAUD_DIV - 1);
  localparam logic [11:0] HALF_LAST = 12'(BAUD_DIV / 2 - 1);

  // Transmitter: 10-bit frame {stop, data, start}; bit 0 drives the line, and
  // ones shift in so the register naturally rests at the idle level.
  logic [9:0]  tx_shift_reg;
  logic [11:0] tx_baud_reg;
  logic [3:0]  tx_bit_reg;
  logic        tx_busy_reg;

  assign tx_done = tx_busy_reg && (tx_baud_reg == BAUD_LAST) && (tx_bit_reg == 4'd9);
  assign tx_busy = tx_busy_reg;
  assign tx      = tx_shift_reg[0];

  always_ff @(posedge clk) begin
    if (srst) begin
      tx_shift_reg <= '1;
      tx_baud_reg  <= '0;
      tx_bit_reg   <= '0;
      tx_busy_reg  <= 1'b0;
    end else if (tx_load) begin
      tx_shift_reg <= {1'b1, tx_data, 1'b0};
      tx_baud_reg  <= '0;
      tx_bit_reg   <= '0;
      tx_busy_reg  <= 1'b1;
    end else if (tx_busy_reg) begin
      if (tx_baud_reg == BAUD_LAST) begin
        tx_baud_reg  <= '0;
        tx_shift_reg <= {1'b1, tx_shift_reg[9:1]};
        if (tx_bit_reg == 4'd9) begin
          tx_busy_reg <= 1'b0;
        end else begin
          tx_bit_reg <= tx_bit_reg + 4'd1;
        end
      end else begin
        tx_baud_reg <= tx_baud_reg + 12'd1;
      end
    end
  end

`ifdef REMOTE_COMM_RX_EN
  // Two-flop synchronizer plus one history flop for falling-edge detection.
  logic        rx_meta_reg, rx_sync_reg, rx_prev_reg;
  logic        rx_busy_reg, rx_rdy_reg;
  logic [11:0] rx_baud_reg;
  logic [3:0]  rx_bit_reg;
  logic [7:0]  rx_shift_reg, rx_data_reg;
  logic        rx_fall;

  assign rx_fall = rx_prev_reg & ~rx_sync_reg;
  assign rx_data = rx_data_reg;
  assign rx_rdy  = rx_rdy_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      rx_meta_reg  <= 1'b1;
      rx_sync_reg  <= 1'b1;
      rx_prev_reg  <= 1'b1;
      rx_busy_reg  <= 1'b0;
      rx_rdy_reg   <= 1'b0;
      rx_baud_reg  <= '0;
      rx_bit_reg   <= '0;
      rx_shift_reg <= '0;
      rx_data_reg  <= '0;
    end else begin
      rx_meta_reg <= rx;
      rx_sync_reg <= rx_meta_reg;
      rx_prev_reg <= rx_sync_reg;
      if (!rx_busy_reg) begin
        if (rx_fall) begin
          rx_busy_reg <= 1'b1;
          rx_rdy_reg  <= 1'b0;
          rx_baud_reg <= '0;
          rx_bit_reg  <= '0;
        end
      end else begin
        // Mid-bit sample: bit 0 is the start bit, 1..8 data, 9 the stop bit
        // (whose value is ignored; it just marks the byte as complete).
        if (rx_baud_reg == HALF_LAST) begin
          if (rx_bit_reg == 4'd9) begin
            rx_data_reg <= rx_shift_reg;
            rx_rdy_reg  <= 1'b1;
            rx_busy_reg <= 1'b0;
          end else if (rx_bit_reg != 4'd0) begin
            rx_shift_reg <= {rx_sync_reg, rx_shift_reg[7:1]};
          end
        end
        if (rx_baud_reg == BAUD_LAST) begin
          rx_baud_reg <= '0;
          rx_bit_reg  <= rx_bit_reg + 4'd1;
        end else begin
          rx_baud_reg <= rx_baud_reg + 12'd1;
        end
      end
    end
  end
`else
  logic unused_rx;
  assign unused_rx = rx;
  assign rx_data   = 8'h00;
  assign rx_rdy    = 1'b0;
`endif

endmodule

// File: rtl/remote_comm.sv
// remote_comm: host-side UART command link. Sends a 16-bit command as two
// back-to-back 8N1 bytes (high byte first) and receives 8-bit responses.
// Optional receiver: REMOTE_COMM_RX_EN (undefined -> resp_rdy=0, resp=0x00).
// Ports:
//   clk        clock
//   rst_n      synchronous reset, active HIGH (name kept for compatibility)
//   RX         serial in from robot TX (asynchronous, idles high)
//   TX         serial out to robot RX (idles high)
//   cmd        command word, sampled when snd_cmd is accepted
//   snd_cmd    start request, honoured only when idle
//   cmd_snt    set at end of low-byte stop bit, cleared on next accept
//   resp_rdy   response byte received, cleared on next start bit
//   resp       last received byte
module remote_comm
  import remote_comm_pkg::*;
#(
  parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  input  logic [15:0] cmd,
  input  logic        snd_cmd,
  output logic        cmd_snt,
  output logic        resp_rdy,
  output logic [7:0]  resp
);

  tx_state_t   state_reg, state_next;
  logic [15:0] cmd_reg;
  logic        cmd_snt_reg;
  // One-cycle delay between accepting a command and loading the high byte,
  // so the start bit appears on the edge after snd_cmd is sampled.
  logic        start_reg;

  logic        accept;
  logic        tx_load;
  logic [7:0]  tx_data;
  logic        tx_done;
  logic        tx_busy_unused;

  // State register and command datapath
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_reg   <= IDLE;
      cmd_reg     <= '0;
      cmd_snt_reg <= 1'b0;
      start_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      start_reg <= accept;
      if (accept) begin
        cmd_reg     <= cmd;
        cmd_snt_reg <= 1'b0;
      end else if (state_reg == TX_LOW && tx_done) begin
        cmd_snt_reg <= 1'b1;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (snd_cmd) state_next = TX_HIGH;
      TX_HIGH: if (tx_done) state_next = TX_LOW;
      TX_LOW:  if (tx_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs: the low byte loads on the very cycle the high byte finishes.
  always_comb begin
    accept  = (state_reg == IDLE) && snd_cmd;
    tx_load = start_reg || (state_reg == TX_HIGH && tx_done);
    tx_data = start_reg ? cmd_reg[15:8] : cmd_reg[7:0];
  end

  assign cmd_snt = cmd_snt_reg;

  remote_uart #(
    .BAUD_DIV (BAUD_DIV)
  ) u_uart (
    .clk     (clk),
    .srst    (rst_n),
    .tx_load (tx_load),
    .tx_data (tx_data),
    .tx_busy (tx_busy_unused),
    .tx_done (tx_done),
    .tx      (TX),
    .rx      (RX),
    .rx_data (resp),
    .rx_rdy  (resp_rdy)
  );

endmodule

// File: tb/tb_remote_comm.sv
module tb_remote_comm;
  import remote_comm_pkg::*;

  localparam int B = 16;
`ifdef REMOTE_COMM_RX_EN
  localparam bit RX_EN = 1'b1;
`else
  localparam bit RX_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        rx_drive = 1'b1;
  logic        loopback = 1'b0;
  logic        rx_line;
  logic        tx;
  logic [15:0] cmd = 16'h0000;
  logic        snd_cmd = 1'b0;
  logic        cmd_snt;
  logic        resp_rdy;
  logic [7:0]  resp;

  int vectors = 0;
  int fails = 0;

  assign rx_line = loopback ? tx : rx_drive;

  always #5 clk = ~clk;

  remote_comm #(.BAUD_DIV(B)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .RX       (rx_line),
    .TX       (tx),
    .cmd      (cmd),
    .snd_cmd  (snd_cmd),
    .cmd_snt  (cmd_snt),
    .resp_rdy (resp_rdy),
    .resp     (resp)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock; returns at the following falling edge (sampling point).
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Sends word and checks every bit mid-way plus cmd_snt timing (321 cycles).
  task automatic send_and_check(input logic [15:0] word, input bit inject_busy);
    logic [7:0] byte_v;
    logic       exp_bit;
    int         k, j;
    cmd = word;
    snd_cmd = 1'b1;
    tick();
    snd_cmd = 1'b0;
    cmd = 16'hDEAD;
    for (int c = 1; c <= 321; c++) begin
      tick();
      if (inject_busy && c == 40) begin
        cmd = 16'h1234;
        snd_cmd = 1'b1;
      end
      if (inject_busy && c == 41) begin
        snd_cmd = 1'b0;
        cmd = 16'hDEAD;
      end
      if (c == 1) check("cmd_snt cleared", cmd_snt, 1'b0);
      if (c - 1 < 20 * B && (c - 1) % B == B / 2) begin
        k = (c - 1) / B;
        j = k % 10;
        byte_v = (k < 10) ? word[15:8] : word[7:0];
        exp_bit = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : byte_v[j - 1];
        check($sformatf("tx %04h bit %0d", word, k), tx, exp_bit);
      end
      if (c == 320) check("cmd_snt at 320", cmd_snt, 1'b0);
      if (c == 321) check("cmd_snt at 321", cmd_snt, 1'b1);
    end
  endtask

  // Drives frame bits first..9 of {stop, b, start}, B cycles each.
  task automatic drive_rx(input logic [7:0] b, input int first);
    logic [9:0] frame;
    frame = {1'b1, b, 1'b0};
    for (int j = first; j < 10; j++) begin
      rx_drive = frame[j];
      repeat (B) tick();
    end
  endtask

  initial begin
    int         rises;
    logic       prev_rdy;
    logic [7:0] first_resp;

    // Reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset TX", tx, 1'b1);
    check("reset cmd_snt", cmd_snt, 1'b0);
    check("reset resp_rdy", resp_rdy, 1'b0);
    check("reset resp", resp, 8'h00);
    rst_n = 1'b0;
    repeat (3) tick();

    // Send 0x4BF1 with an ignored request for 0x1234 mid-byte
    send_and_check(16'h4BF1, 1'b1);
    repeat (5) tick();
    check("cmd_snt holds", cmd_snt, 1'b1);

    // Receive 0xA5, then a second frame whose start clears resp_rdy
    drive_rx(POS_ACK, 0);
    check("rx resp A5", resp, RX_EN ? 8'hA5 : 8'h00);
    check("rx rdy A5", resp_rdy, RX_EN);
    rx_drive = 1'b0;
    repeat (4) tick();
    check("rx rdy cleared", resp_rdy, 1'b0);
    check("rx resp held", resp, RX_EN ? 8'hA5 : 8'h00);
    repeat (B - 4) tick();
    drive_rx(8'h3C, 1);
    check("rx resp 3C", resp, RX_EN ? 8'h3C : 8'h00);
    check("rx rdy 3C", resp_rdy, RX_EN);
    repeat (B) tick();

    // Loopback 0x2000: expect receptions 0x20 then 0x00
    loopback = 1'b1;
    rises = 0;
    first_resp = 8'hEE;
    prev_rdy = resp_rdy;
    cmd = 16'h2000;
    snd_cmd = 1'b1;
    tick();
    snd_cmd = 1'b0;
    for (int c = 1; c <= 340; c++) begin
      tick();
      if (resp_rdy && !prev_rdy) begin
        if (rises == 0) first_resp = resp;
        rises++;
      end
      prev_rdy = resp_rdy;
    end
    check("loop receptions", 16'(rises), RX_EN ? 16'd2 : 16'd0);
    check("loop first byte", first_resp, RX_EN ? 8'h20 : 8'hEE);
    check("loop second byte", resp, 8'h00);
    check("loop cmd_snt", cmd_snt, 1'b1);
    loopback = 1'b0;
    repeat (B) tick();

    // Reset in the middle of bit 5 of a frame
    cmd = 16'h00FF;
    snd_cmd = 1'b1;
    tick();
    snd_cmd = 1'b0;
    repeat (1 + 5 * B + B / 2) tick();
    check("mid-frame TX low", tx, 1'b0);
    rst_n = 1'b1;
    tick();
    check("mid reset TX", tx, 1'b1);
    check("mid reset cmd_snt", cmd_snt, 1'b0);
    check("mid reset resp_rdy", resp_rdy, 1'b0);
    rst_n = 1'b0;
    repeat (3 * B) tick();
    check("no resume TX", tx, 1'b1);
    send_and_check(16'h0001, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
